arcade_input_hub: RTL and testbench

- Parametrised input front-end for arcade cores.
- Merges hps_io joysticks and PS/2 keyboard events into per-player active-high controls.
- Stretches coin pulses to a minimum width, generates pause/service/reset requests, and loads DIP-switch bytes from the ioctl stream.
- Sits between hps_io and the game core; replaces per-core hand-written key decoders.

---
 rtl/arcade_input_pkg.sv | 78 +++++++
 rtl/coin_stretch.sv | 41 ++++
 rtl/arcade_input_hub.sv | 211 +++++++++++++++++++++
 tb/tb_arcade_input_hub.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg
// Shared constants for the arcade input hub:
//   - hps_io joystick bit positions (start/select/coin/pause move with BUTTONS)
//   - PS/2 scancodes, as {extended, code} 9-bit values
//   - ioctl download index carrying DIP-switch bytes
//   - per-player direction struct and opposing-direction cleanup helper
package arcade_input_pkg;

  localparam int BIT_RIGHT = 0;
  localparam int BIT_LEFT  = 1;
  localparam int BIT_DOWN  = 2;
  localparam int BIT_UP    = 3;
  localparam int BIT_BTN0  = 4;

  // Start sits directly after the game buttons; select, coin, pause follow it
  function automatic int start_bit(int buttons);
    return BIT_BTN0 + buttons;
  endfunction

  function automatic int select_bit(int buttons);
    return start_bit(buttons) + 1;
  endfunction

  function automatic int coin_bit(int buttons);
    return start_bit(buttons) + 2;
  endfunction

  function automatic int pause_bit(int buttons);
    return start_bit(buttons) + 3;
  endfunction

  // Bit 8 is the extended (E0) prefix, so arrows never alias keypad keys
  localparam logic [8:0] KEY_UP    = 9'h175;
  localparam logic [8:0] KEY_DOWN  = 9'h172;
  localparam logic [8:0] KEY_LEFT  = 9'h16B;
  localparam logic [8:0] KEY_RIGHT = 9'h174;
  localparam logic [8:0] KEY_LCTRL = 9'h014;
  localparam logic [8:0] KEY_LALT  = 9'h011;
  localparam logic [8:0] KEY_SPACE = 9'h029;
  localparam logic [8:0] KEY_1     = 9'h016;
  localparam logic [8:0] KEY_5     = 9'h02E;
  localparam logic [8:0] KEY_R     = 9'h02D;
  localparam logic [8:0] KEY_D     = 9'h023;
  localparam logic [8:0] KEY_F     = 9'h02B;
  localparam logic [8:0] KEY_G     = 9'h034;
  localparam logic [8:0] KEY_A     = 9'h01C;
  localparam logic [8:0] KEY_S     = 9'h01B;
  localparam logic [8:0] KEY_Q     = 9'h015;
  localparam logic [8:0] KEY_2     = 9'h01E;
  localparam logic [8:0] KEY_6     = 9'h036;
  localparam logic [8:0] KEY_9     = 9'h046;
  localparam logic [8:0] KEY_F3    = 9'h004;

  localparam logic [7:0] DSW_IOCTL_INDEX = 8'd254;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } dir_t;

  // Opposing directions cancel each other out
  function automatic dir_t socd_clean(dir_t d);
    dir_t r;
    r = d;
    if (d.up && d.down) begin
      r.up   = 1'b0;
      r.down = 1'b0;
    end
    if (d.left && d.right) begin
      r.left  = 1'b0;
      r.right = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/coin_stretch.sv
// coin_stretch
// Single-channel coin pulse stretcher. A rising edge on raw (re)loads a
// down-counter with COIN_CYC; coin is high while the counter is nonzero or
// raw itself is high, so a held coin never drops early.
// Ports:
//   clk_sys  system clock
//   reset_n  asynchronous active-low reset (cuts a running pulse at once)
//   raw      registered merged coin request
//   coin     stretched coin output
module coin_stretch #(
  parameter int COIN_CYC = 1048576
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic raw,
  output logic coin
);

  localparam int CW = $clog2(COIN_CYC + 1);

  logic [CW-1:0] count;
  logic          raw_d;

  // Edge detect on raw; a new edge restarts the count even mid-pulse
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      raw_d <= 1'b0;
    end else begin
      raw_d <= raw;
      if (raw && !raw_d) begin
        count <= CW'(COIN_CYC);
      end else if (count != '0) begin
        count <= count - CW'(1);
      end
    end
  end

  assign coin = (count != '0) | raw;

endmodule

// File: rtl/arcade_input_hub.sv
// arcade_input_hub
// Merges hps_io joysticks and PS/2 keyboard events into per-player
// active-high controls, stretches coin pulses, and captures DIP-switch
// bytes from the ioctl download stream.
// Optional build macro: INPUT_HUB_SOCD_EN -- when defined, opposing
// directions (up+down, left+right) cancel per player before the output
// register; otherwise they pass through unchanged.
// Ports:
//   clk_sys, reset_n      clock, asynchronous active-low reset
//   ps2_key[10:0]         {toggle, pressed, extended, scancode}
//   joystick              player p at [16p+15:16p]
//   ioctl_wr/index/addr/dout  download stream (index 254 = DIP bytes)
//   dir                   per player {up,down,left,right}
//   btn, start, coin      per player buttons, start, stretched coin
//   service, key_reset    keyboard 9 and F3
//   pause_req             OR of every player's pause bit
//   dsw                   DIP bytes, stored inverted, reset to all ones
module arcade_input_hub
  import arcade_input_pkg::*;
#(
  parameter int PLAYERS   = 2,
  parameter int BUTTONS   = 2,
  parameter int DSW_BYTES = 2,
  parameter int COIN_CYC  = 1048576
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [10:0]              ps2_key,
  input  logic [PLAYERS*16-1:0]    joystick,
  input  logic                     ioctl_wr,
  input  logic [7:0]               ioctl_index,
  input  logic [24:0]              ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  output logic [PLAYERS*4-1:0]     dir,
  output logic [PLAYERS*BUTTONS-1:0] btn,
  output logic [PLAYERS-1:0]       start,
  output logic [PLAYERS-1:0]       coin,
  output logic                     service,
  output logic                     key_reset,
  output logic                     pause_req,
  output logic [DSW_BYTES*8-1:0]   dsw
);

  localparam int SB = start_bit(BUTTONS);

  logic       primed;
  logic       old_tog;
  logic [3:0] kb_dir [2];
  logic [2:0] kb_btn [2];
  logic [1:0] kb_start;
  logic [1:0] kb_coin;
  logic       kb_service;
  logic       kb_reset;
  logic [8:0] key_code;
  logic       key_event;
  logic [PLAYERS-1:0] pause_bits;
  logic       unused_kb;

  assign key_code  = ps2_key[8:0];
  assign key_event = primed && (ps2_key[10] != old_tog);

  // Keyboard latches follow the pressed flag of each toggle event. The first
  // clock after reset only samples the toggle so a stale one is not decoded.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      primed     <= 1'b0;
      old_tog    <= 1'b0;
      kb_dir     <= '{default: '0};
      kb_btn     <= '{default: '0};
      kb_start   <= '0;
      kb_coin    <= '0;
      kb_service <= 1'b0;
      kb_reset   <= 1'b0;
    end else begin
      primed  <= 1'b1;
      old_tog <= ps2_key[10];
      if (key_event) begin
        case (key_code)
          KEY_UP:    kb_dir[0][BIT_UP]    <= ps2_key[9];
          KEY_DOWN:  kb_dir[0][BIT_DOWN]  <= ps2_key[9];
          KEY_LEFT:  kb_dir[0][BIT_LEFT]  <= ps2_key[9];
          KEY_RIGHT: kb_dir[0][BIT_RIGHT] <= ps2_key[9];
          KEY_LCTRL: kb_btn[0][0]         <= ps2_key[9];
          KEY_LALT:  kb_btn[0][1]         <= ps2_key[9];
          KEY_SPACE: kb_btn[0][2]         <= ps2_key[9];
          KEY_1:     kb_start[0]          <= ps2_key[9];
          KEY_5:     kb_coin[0]           <= ps2_key[9];
          KEY_R:     kb_dir[1][BIT_UP]    <= ps2_key[9];
          KEY_F:     kb_dir[1][BIT_DOWN]  <= ps2_key[9];
          KEY_D:     kb_dir[1][BIT_LEFT]  <= ps2_key[9];
          KEY_G:     kb_dir[1][BIT_RIGHT] <= ps2_key[9];
          KEY_A:     kb_btn[1][0]         <= ps2_key[9];
          KEY_S:     kb_btn[1][1]         <= ps2_key[9];
          KEY_Q:     kb_btn[1][2]         <= ps2_key[9];
          KEY_2:     kb_start[1]          <= ps2_key[9];
          KEY_6:     kb_coin[1]           <= ps2_key[9];
          KEY_9:     kb_service           <= ps2_key[9];
          KEY_F3:    kb_reset             <= ps2_key[9];
          default:   ;
        endcase
      end
    end
  end

  // Latches not wired to an output in narrow configurations are sunk here
  assign unused_kb = ^{kb_btn[0], kb_btn[1], kb_dir[1], kb_start, kb_coin};

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    // Player p's start is also asserted by the previous player's select
    localparam int SRC = (p + PLAYERS - 1) % PLAYERS;

    logic [15:0]        joy;
    logic               sel_in;
    logic [3:0]         k_dir;
    logic [BUTTONS-1:0] k_btn;
    logic               k_start;
    logic               k_coin;
    dir_t               m_dir;
    logic [3:0]         dir_q;
    logic [BUTTONS-1:0] btn_q;
    logic               start_q;
    logic               coin_raw_q;
    logic               unused_joy;

    assign joy        = joystick[16*p +: 16];
    assign sel_in     = joystick[16*SRC + select_bit(BUTTONS)];
    assign unused_joy = ^joy;

    if (p < 2) begin : g_kb
      assign k_dir   = kb_dir[p];
      assign k_start = kb_start[p];
      assign k_coin  = kb_coin[p];
      for (genvar b = 0; b < BUTTONS; b++) begin : g_btn
        if (b < 3) begin : g_mapped
          assign k_btn[b] = kb_btn[p][b];
        end else begin : g_unmapped
          assign k_btn[b] = 1'b0;
        end
      end
    end else begin : g_nokb
      assign k_dir   = '0;
      assign k_btn   = '0;
      assign k_start = 1'b0;
      assign k_coin  = 1'b0;
    end

    // Merged directions, optionally with opposing inputs cancelled
    always_comb begin
      m_dir = dir_t'(joy[3:0] | k_dir);
`ifdef INPUT_HUB_SOCD_EN
      m_dir = socd_clean(m_dir);
`endif
    end

    // One register stage for every merged control
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        dir_q      <= '0;
        btn_q      <= '0;
        start_q    <= 1'b0;
        coin_raw_q <= 1'b0;
      end else begin
        dir_q      <= m_dir;
        btn_q      <= joy[BIT_BTN0 +: BUTTONS] | k_btn;
        start_q    <= joy[SB] | sel_in | k_start;
        coin_raw_q <= joy[coin_bit(BUTTONS)] | k_coin;
      end
    end

    assign dir[4*p +: 4]             = dir_q;
    assign btn[BUTTONS*p +: BUTTONS] = btn_q;
    assign start[p]                  = start_q;
    assign pause_bits[p]             = joy[pause_bit(BUTTONS)];

    coin_stretch #(
      .COIN_CYC (COIN_CYC)
    ) u_coin (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .raw     (coin_raw_q),
      .coin    (coin[p])
    );
  end

  // Shared single-bit outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      service   <= 1'b0;
      key_reset <= 1'b0;
      pause_req <= 1'b0;
    end else begin
      service   <= kb_service;
      key_reset <= kb_reset;
      pause_req <= |pause_bits;
    end
  end

  // DIP bytes arrive on ioctl index 254; out-of-range addresses fall through
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dsw <= '1;
    end else if (ioctl_wr && (ioctl_index == DSW_IOCTL_INDEX)) begin
      for (int k = 0; k < DSW_BYTES; k++) begin
        if (ioctl_addr == 25'(k)) begin
          dsw[8*k +: 8] <= ~ioctl_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_arcade_input_hub.sv
// tb_arcade_input_hub
// Directed bench for arcade_input_hub with PLAYERS=2, BUTTONS=2,
// DSW_BYTES=2, COIN_CYC=8. Expected opposing-direction behaviour follows
// INPUT_HUB_SOCD_EN as defined for the build.
module tb_arcade_input_hub;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [31:0] joystick;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  dir;
  logic [3:0]  btn;
  logic [1:0]  start;
  logic [1:0]  coin;
  logic        service;
  logic        key_reset;
  logic        pause_req;
  logic [15:0] dsw;

  logic tog;
  int   tests_run = 0;
  int   tests_failed = 0;

  arcade_input_hub #(
    .PLAYERS   (2),
    .BUTTONS   (2),
    .DSW_BYTES (2),
    .COIN_CYC  (8)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_key     (ps2_key),
    .joystick    (joystick),
    .ioctl_wr    (ioctl_wr),
    .ioctl_index (ioctl_index),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .dir         (dir),
    .btn         (btn),
    .start       (start),
    .coin        (coin),
    .service     (service),
    .key_reset   (key_reset),
    .pause_req   (pause_req),
    .dsw         (dsw)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One keyboard event; its effect is visible two clocks later
  task automatic send_key(input logic ext, input logic [7:0] code, input logic pressed);
    tog = ~tog;
    ps2_key = {tog, pressed, ext, code};
    tick();
    tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    tests_run++;
    if ({dir, btn, start, coin, service, key_reset, pause_req} !== 19'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %h, want 0", {dir, btn, start, coin, service, key_reset, pause_req});
    end
    tests_run++;
    if (dsw !== 16'hFFFF) begin
      tests_failed++;
      $display("[TB] FAIL reset_dsw: got %h, want ffff", dsw);
    end
    reset_n = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (start !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL stale_toggle: start got %b, want 00", start);
    end
    tog = 1'b0;
    ps2_key = {tog, 1'b1, 1'b0, 8'h16};
    tick();
    tests_run++;
    if (start !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL key_latency: start got %b after 1 cycle, want 00", start);
    end
    tick();
    tests_run++;
    if (start !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL key1_press: start got %b, want 01", start);
    end
    send_key(1'b0, 8'h16, 1'b0);
    tests_run++;
    if (start !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL key1_release: start got %b, want 00", start);
    end
  endtask

  task automatic test_coin();
    int highs;
    highs = 0;
    joystick[24] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) joystick[24] = 1'b0;
      if (coin[1] === 1'b1) highs++;
    end
    tests_run++;
    if (highs != 9) begin
      tests_failed++;
      $display("[TB] FAIL coin_pulse_width: got %0d cycles, want 9", highs);
    end
    tests_run++;
    if (coin[0] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL coin_other_player: coin[0] got %b, want 0", coin[0]);
    end
    highs = 0;
    joystick[24] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (coin[1] === 1'b1) highs++;
      if (i == 11) joystick[24] = 1'b0;
    end
    tests_run++;
    if (highs != 12) begin
      tests_failed++;
      $display("[TB] FAIL coin_held: got %0d cycles, want 12", highs);
    end
    joystick[24] = 1'b1;
    tick();
    joystick[24] = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (coin[1] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL coin_mid_pulse: got %b, want 1", coin[1]);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (coin[1] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL coin_async_reset: got %b, want 0", coin[1]);
    end
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_extended();
    send_key(1'b1, 8'h75, 1'b1);
    tests_run++;
    if (dir !== 8'b0000_1000) begin
      tests_failed++;
      $display("[TB] FAIL ext_up_press: dir got %b, want 00001000", dir);
    end
    send_key(1'b1, 8'h75, 1'b0);
    send_key(1'b0, 8'h75, 1'b1);
    tests_run++;
    if (dir !== 8'b0000_0000) begin
      tests_failed++;
      $display("[TB] FAIL nonext_075: dir got %b, want 00000000", dir);
    end
    send_key(1'b1, 8'h6B, 1'b1);
    send_key(1'b0, 8'h2D, 1'b1);
    tests_run++;
    if (dir !== 8'b1000_0010) begin
      tests_failed++;
      $display("[TB] FAIL left_and_p1_up: dir got %b, want 10000010", dir);
    end
    send_key(1'b1, 8'h6B, 1'b0);
    send_key(1'b0, 8'h2D, 1'b0);
    send_key(1'b0, 8'h29, 1'b1);
    tests_run++;
    if (btn !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL space_ignored: btn got %b, want 0000", btn);
    end
    send_key(1'b0, 8'h14, 1'b1);
    send_key(1'b0, 8'h1B, 1'b1);
    tests_run++;
    if (btn !== 4'b1001) begin
      tests_failed++;
      $display("[TB] FAIL kb_buttons: btn got %b, want 1001", btn);
    end
    send_key(1'b0, 8'h14, 1'b0);
    send_key(1'b0, 8'h1B, 1'b0);
    send_key(1'b0, 8'h29, 1'b0);
  endtask

  task automatic test_dsw();
    ioctl_wr = 1'b1;
    ioctl_index = 8'd254;
    ioctl_addr = 25'd0; ioctl_dout = 8'h3C; tick();
    ioctl_addr = 25'd1; ioctl_dout = 8'h00; tick();
    ioctl_addr = 25'd2; ioctl_dout = 8'h55; tick();
    ioctl_index = 8'd0;
    ioctl_addr = 25'd0; ioctl_dout = 8'hFF; tick();
    ioctl_wr = 1'b0;
    tick();
    tests_run++;
    if (dsw !== 16'hFFC3) begin
      tests_failed++;
      $display("[TB] FAIL dsw_capture: got %h, want ffc3", dsw);
    end
    ioctl_wr = 1'b1;
    ioctl_index = 8'd254;
    ioctl_addr = 25'd1; ioctl_dout = 8'h0F; tick();
    ioctl_wr = 1'b0;
    tick();
    tests_run++;
    if (dsw !== 16'hF0C3) begin
      tests_failed++;
      $display("[TB] FAIL dsw_byte1: got %h, want f0c3", dsw);
    end
  endtask

  task automatic test_select();
    joystick = 32'h0000_0080;
    tick();
    tests_run++;
    if (start !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL select_p0: start got %b, want 10", start);
    end
    joystick = 32'h0080_0000;
    tick();
    tests_run++;
    if (start !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL select_p1: start got %b, want 01", start);
    end
    joystick = 32'h0030_0000;
    tick();
    tests_run++;
    if (btn !== 4'b1100) begin
      tests_failed++;
      $display("[TB] FAIL joy_buttons_p1: btn got %b, want 1100", btn);
    end
    joystick = 32'h0;
    tick();
  endtask

  task automatic test_socd();
    logic [7:0] want_a;
    logic [7:0] want_b;
`ifdef INPUT_HUB_SOCD_EN
    want_a = 8'h01;
    want_b = 8'h08;
`else
    want_a = 8'h0D;
    want_b = 8'h3B;
`endif
    joystick = 32'h0000_000D;
    tick();
    tests_run++;
    if (dir !== want_a) begin
      tests_failed++;
      $display("[TB] FAIL socd_up_down: dir got %h, want %h", dir, want_a);
    end
    joystick = 32'h0003_000B;
    tick();
    tests_run++;
    if (dir !== want_b) begin
      tests_failed++;
      $display("[TB] FAIL socd_left_right: dir got %h, want %h", dir, want_b);
    end
    joystick = 32'h0;
    tick();
  endtask

  task automatic test_misc();
    send_key(1'b0, 8'h46, 1'b1);
    send_key(1'b0, 8'h04, 1'b1);
    tests_run++;
    if ({service, key_reset} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL service_f3: got %b, want 11", {service, key_reset});
    end
    send_key(1'b0, 8'h46, 1'b0);
    send_key(1'b0, 8'h04, 1'b0);
    send_key(1'b0, 8'h2E, 1'b1);
    tests_run++;
    if (coin !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL kb_coin5: coin got %b, want 01", coin);
    end
    send_key(1'b0, 8'h2E, 1'b0);
    joystick = 32'h0200_0000;
    tick();
    tests_run++;
    if (pause_req !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pause_p1: got %b, want 1", pause_req);
    end
    joystick = 32'h0;
    tick();
    tests_run++;
    if (pause_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL pause_clear: got %b, want 0", pause_req);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    tog         = 1'b1;
    ps2_key     = {1'b1, 1'b1, 1'b0, 8'h16};
    joystick    = 32'h0;
    ioctl_wr    = 1'b0;
    ioctl_index = 8'd0;
    ioctl_addr  = 25'd0;
    ioctl_dout  = 8'd0;
    test_reset();
    test_coin();
    test_extended();
    test_dsw();
    test_select();
    test_socd();
    test_misc();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
